// File: rtl/prog_loader.sv
// Program-memory loader: turns a framed UART byte stream into 14-bit words written from address 0.
// Write lands one cycle after its W_LO byte; no backpressure, bytes are consumed only on rx_valid.
module prog_loader #(
  parameter int         ADDR_W        = 11,
  parameter logic [7:0] SYNC_BYTE     = 8'hA5,
  parameter int         TIMEOUT       = 1000000,
  parameter bit         HOLD_AT_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              pm_we,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [13:0]       pm_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int IDX_W = (ADDR_W + 1 > 12) ? ADDR_W + 1 : 12;

  localparam logic [1:0] E_FMT = 2'd1;
  localparam logic [1:0] E_TMO = 2'd2;
  localparam logic [1:0] E_CHK = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_CNT_HI, S_CNT_LO, S_W_HI, S_W_LO, S_CHK} state_t;

  state_t             r_state;
  logic [7:0]         r_sum;
  logic [3:0]         r_cnt_hi;
  logic [IDX_W-1:0]   r_n;
  logic [IDX_W-1:0]   r_idx;
  logic [5:0]         r_w_hi;
  logic [TMO_W-1:0]   r_tmo;
  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [13:0]        r_wdata;
  logic               r_hold;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic [1:0]         r_code;

  logic [7:0]         w_sum;
  logic [IDX_W-1:0]   w_n;
  logic [IDX_W-1:0]   w_idx_nx;
  logic               w_tmo_exp;
  logic               w_n_bad;

  assign w_sum     = r_sum + rx_data;
  assign w_n       = IDX_W'({r_cnt_hi, rx_data});
  assign w_idx_nx  = r_idx + IDX_W'(1);
  assign w_tmo_exp = (r_tmo == TMO_W'(TIMEOUT - 1));
  assign w_n_bad   = (w_n == '0) || (w_n > IDX_W'(2 ** ADDR_W));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_sum    <= '0;
      r_cnt_hi <= '0;
      r_n      <= '0;
      r_idx    <= '0;
      r_w_hi   <= '0;
      r_tmo    <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_hold   <= HOLD_AT_RESET;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_code   <= '0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;

      // Inter-byte watchdog only runs inside a frame; any byte restarts it.
      if (r_state != S_IDLE && !rx_valid) r_tmo <= r_tmo + 1'b1;
      else                                r_tmo <= '0;

      if (rx_valid) begin
        if (r_state != S_IDLE) r_sum <= w_sum;
        case (r_state)
          S_IDLE: begin
            if (rx_data == SYNC_BYTE) begin
              r_state <= S_CNT_HI;
              r_busy  <= 1'b1;
              r_sum   <= '0;
              r_idx   <= '0;
              r_code  <= '0;
              r_hold  <= 1'b1;
            end
          end
          S_CNT_HI: begin
            if (rx_data[7:4] != 4'h0) begin
              r_state <= S_IDLE; r_busy <= 1'b0; r_err <= 1'b1; r_code <= E_FMT;
            end else begin
              r_cnt_hi <= rx_data[3:0];
              r_state  <= S_CNT_LO;
            end
          end
          S_CNT_LO: begin
            if (w_n_bad) begin
              r_state <= S_IDLE; r_busy <= 1'b0; r_err <= 1'b1; r_code <= E_FMT;
            end else begin
              r_n     <= w_n;
              r_state <= S_W_HI;
            end
          end
          S_W_HI: begin
            if (rx_data[7:6] != 2'b00) begin
              r_state <= S_IDLE; r_busy <= 1'b0; r_err <= 1'b1; r_code <= E_FMT;
            end else begin
              r_w_hi  <= rx_data[5:0];
              r_state <= S_W_LO;
            end
          end
          S_W_LO: begin
            r_we    <= 1'b1;
            r_addr  <= r_idx[ADDR_W-1:0];
            r_wdata <= {r_w_hi, rx_data};
            r_idx   <= w_idx_nx;
            r_state <= (w_idx_nx == r_n) ? S_CHK : S_W_HI;
          end
          S_CHK: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            if (w_sum == 8'h00) begin
              r_done <= 1'b1;
              r_hold <= 1'b0;
            end else begin
              r_err  <= 1'b1;
              r_code <= E_CHK;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end else if (r_state != S_IDLE && w_tmo_exp) begin
        r_state <= S_IDLE; r_busy <= 1'b0; r_err <= 1'b1; r_code <= E_TMO;
      end
    end
  end

  assign pm_we    = r_we;
  assign pm_addr  = r_addr;
  assign pm_wdata = r_wdata;
  assign cpu_hold = r_hold;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;
  assign err_code = r_code;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: frames are built from word lists and the expected writes/status follow from them.
module tb_prog_loader;
  localparam int ADDR_W = 11;
  localparam int TMO    = 16;

  typedef logic [7:0]  bq_t[$];
  typedef logic [13:0] wq_t[$];

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              pm_we;
  logic [ADDR_W-1:0] pm_addr;
  logic [13:0]       pm_wdata;
  logic              cpu_hold, busy, done, err;
  logic [1:0]        err_code;

  prog_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5), .TIMEOUT(TMO), .HOLD_AT_RESET(1'b1)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .pm_we(pm_we), .pm_addr(pm_addr), .pm_wdata(pm_wdata), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Monitor: every write, done and err pulse with the cycle it was seen in.
  logic [ADDR_W-1:0] wa_q[$];
  logic [13:0]       wd_q[$];
  int                wc_q[$];
  int done_n = 0, err_n = 0, both_n = 0, done_cyc = 0, err_cyc = 0;
  always @(negedge clk) begin
    if (pm_we) begin
      wa_q.push_back(pm_addr);
      wd_q.push_back(pm_wdata);
      wc_q.push_back(cyc);
    end
    if (done) begin done_n++; done_cyc = cyc; end
    if (err)  begin err_n++;  err_cyc  = cyc; end
    if (done && err) both_n++;
  end

  int bcyc_q[$];

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    bcyc_q.push_back(cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input bq_t f, input int maxgap);
    for (int i = 0; i < f.size(); i++) begin
      send_byte(f[i]);
      if (maxgap > 0) idle(int'($urandom_range(maxgap, 0)));
    end
  endtask

  function automatic bq_t make_frame(input wq_t w, input bit corrupt);
    bq_t f;
    logic [7:0]  s;
    logic [11:0] n;
    n = 12'(w.size());
    f.push_back(8'hA5);
    f.push_back({4'h0, n[11:8]});
    f.push_back(n[7:0]);
    foreach (w[i]) begin
      f.push_back({2'b00, w[i][13:8]});
      f.push_back(w[i][7:0]);
    end
    s = 8'h00;
    for (int i = 1; i < f.size(); i++) s = s + f[i];
    f.push_back(corrupt ? (8'h00 - s) + 8'h01 : (8'h00 - s));
    return f;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    n_cmp++; if ({pm_we, pm_addr, pm_wdata} !== '0) begin n_bad++; $display("FAIL reset_pm got we=%0b a=%h d=%h want 0", pm_we, pm_addr, pm_wdata); end
    n_cmp++; if ({busy, done, err} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b want 000", {busy, done, err}); end
    n_cmp++; if (err_code !== 2'd0) begin n_bad++; $display("FAIL reset_code got %0d want 0", err_code); end
    n_cmp++; if (cpu_hold !== 1'b1) begin n_bad++; $display("FAIL reset_hold got %b want 1", cpu_hold); end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_good_frame();
    bq_t f = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h00, 8'hFF, 8'hB9};
    logic [13:0] exp_d[2] = '{14'h1234, 14'h00FF};
    int w0 = wa_q.size(), d0 = done_n, e0 = err_n, b0 = bcyc_q.size();
    for (int i = 0; i < 7; i++) send_byte(f[i]);
    n_cmp++; if (cpu_hold !== 1'b1) begin n_bad++; $display("FAIL good_hold_pre got %b want 1", cpu_hold); end
    send_byte(f[7]);
    idle(2);
    n_cmp++; if (wa_q.size() - w0 !== 2) begin n_bad++; $display("FAIL good_nwr got %0d want 2", wa_q.size() - w0); end
    for (int i = 0; i < 2 && w0 + i < wa_q.size(); i++) begin
      n_cmp++;
      if (wa_q[w0+i] !== ADDR_W'(i) || wd_q[w0+i] !== exp_d[i] || wc_q[w0+i] !== bcyc_q[b0+4+2*i]) begin
        n_bad++; $display("FAIL good_wr%0d got a=%h d=%h c=%0d want a=%h d=%h c=%0d", i, wa_q[w0+i], wd_q[w0+i], wc_q[w0+i], i, exp_d[i], bcyc_q[b0+4+2*i]);
      end
    end
    n_cmp++; if (done_n - d0 !== 1 || done_cyc !== bcyc_q[b0+7]) begin n_bad++; $display("FAIL good_done got n=%0d c=%0d want n=1 c=%0d", done_n - d0, done_cyc, bcyc_q[b0+7]); end
    n_cmp++; if (cpu_hold !== 1'b0 || err_code !== 2'd0 || err_n !== e0) begin n_bad++; $display("FAIL good_status got hold=%b code=%0d errs=%0d want 0 0 0", cpu_hold, err_code, err_n - e0); end
  endtask

  task automatic test_bad_checksum();
    bq_t f = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h00, 8'hFF, 8'hB8};
    int w0 = wa_q.size(), d0 = done_n, e0 = err_n;
    send_frame(f, 0);
    idle(2);
    n_cmp++; if (wa_q.size() - w0 !== 2) begin n_bad++; $display("FAIL badchk_nwr got %0d want 2", wa_q.size() - w0); end
    n_cmp++; if (err_n - e0 !== 1 || err_code !== 2'd3) begin n_bad++; $display("FAIL badchk_err got n=%0d code=%0d want 1 3", err_n - e0, err_code); end
    n_cmp++; if (done_n !== d0 || cpu_hold !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL badchk_state got done=%0d hold=%b busy=%b want 0 1 0", done_n - d0, cpu_hold, busy); end
  endtask

  task automatic test_format();
    bq_t fr[3];
    fr[0] = '{8'hA5, 8'h10, 8'h00};
    fr[1] = '{8'hA5, 8'h00, 8'h00};
    fr[2] = '{8'hA5, 8'h00, 8'h01, 8'hC0};
    for (int t = 0; t < 3; t++) begin
      int w0 = wa_q.size(), e0 = err_n;
      send_frame(fr[t], 0);
      idle(2);
      n_cmp++;
      if (err_n - e0 !== 1 || err_code !== 2'd1 || wa_q.size() !== w0 || busy !== 1'b0) begin
        n_bad++; $display("FAIL format%0d got errs=%0d code=%0d wr=%0d busy=%b want 1 1 0 0", t, err_n - e0, err_code, wa_q.size() - w0, busy);
      end
    end
  endtask

  task automatic test_random_frames();
    for (int t = 0; t < 8; t++) begin
      wq_t w;
      bq_t f;
      bit corrupt = ($urandom_range(3, 0) == 0);
      int n = int'($urandom_range(12, 1));
      int w0, d0, e0, b0;
      logic [7:0] nz;
      for (int i = 0; i < n; i++) w.push_back(14'($urandom));
      f = make_frame(w, corrupt);
      nz = 8'($urandom);
      if (nz == 8'hA5) nz = 8'h00;
      send_byte(nz);
      w0 = wa_q.size(); d0 = done_n; e0 = err_n; b0 = bcyc_q.size();
      send_frame(f, 3);
      idle(2);
      n_cmp++; if (wa_q.size() - w0 !== n) begin n_bad++; $display("FAIL rnd%0d_nwr got %0d want %0d", t, wa_q.size() - w0, n); end
      for (int i = 0; i < n && w0 + i < wa_q.size(); i++) begin
        n_cmp++;
        if (wa_q[w0+i] !== ADDR_W'(i) || wd_q[w0+i] !== w[i] || wc_q[w0+i] !== bcyc_q[b0+4+2*i]) begin
          n_bad++; $display("FAIL rnd%0d_wr%0d got a=%h d=%h c=%0d want a=%h d=%h c=%0d", t, i, wa_q[w0+i], wd_q[w0+i], wc_q[w0+i], i, w[i], bcyc_q[b0+4+2*i]);
        end
      end
      if (corrupt) begin
        n_cmp++; if (err_n - e0 !== 1 || done_n !== d0 || err_code !== 2'd3 || cpu_hold !== 1'b1) begin n_bad++; $display("FAIL rnd%0d_bad got errs=%0d dones=%0d code=%0d hold=%b want 1 0 3 1", t, err_n - e0, done_n - d0, err_code, cpu_hold); end
      end else begin
        n_cmp++; if (done_n - d0 !== 1 || err_n !== e0 || done_cyc !== bcyc_q[b0+f.size()-1] || cpu_hold !== 1'b0) begin n_bad++; $display("FAIL rnd%0d_ok got dones=%0d errs=%0d c=%0d hold=%b want 1 0 %0d 0", t, done_n - d0, err_n - e0, done_cyc, cpu_hold, bcyc_q[b0+f.size()-1]); end
      end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rnd%0d_busy got %b want 0", t, busy); end
    end
  endtask

  task automatic test_timeout();
    bq_t f;
    wq_t w;
    int e0 = err_n, d0, k, w0;
    send_frame('{8'hA5, 8'h00, 8'h01}, 0);
    k = bcyc_q[bcyc_q.size()-1];
    for (int i = 0; i < 40 && err_n == e0; i++) begin @(negedge clk); #1; end
    @(posedge clk); #1;
    n_cmp++; if (err_n - e0 !== 1) begin n_bad++; $display("FAIL tmo_seen got %0d err pulses want 1", err_n - e0); end
    n_cmp++; if (err_cyc - k !== TMO) begin n_bad++; $display("FAIL tmo_delay got %0d want %0d", err_cyc - k, TMO); end
    n_cmp++; if (err_code !== 2'd2 || busy !== 1'b0) begin n_bad++; $display("FAIL tmo_state got code=%0d busy=%b want 2 0", err_code, busy); end
    w.push_back(14'h3FAB);
    f = make_frame(w, 1'b0);
    e0 = err_n; d0 = done_n; w0 = wa_q.size();
    for (int i = 0; i < 3; i++) send_byte(f[i]);
    idle(TMO - 1);
    send_byte(f[3]);
    n_cmp++; if (err_n !== e0 || busy !== 1'b1) begin n_bad++; $display("FAIL tmo_edge got errs=%0d busy=%b want 0 1", err_n - e0, busy); end
    send_byte(f[4]);
    send_byte(f[5]);
    idle(2);
    n_cmp++; if (done_n - d0 !== 1 || err_n !== e0 || wa_q.size() - w0 !== 1) begin n_bad++; $display("FAIL tmo_edge_done got dones=%0d errs=%0d wr=%0d want 1 0 1", done_n - d0, err_n - e0, wa_q.size() - w0); end
    if (wa_q.size() > w0) begin
      n_cmp++; if (wd_q[w0] !== 14'h3FAB) begin n_bad++; $display("FAIL tmo_edge_word got %h want 3fab", wd_q[w0]); end
    end
  endtask

  task automatic test_max();
    wq_t w;
    bq_t f;
    int w0, d0, e0, bad = 0;
    for (int i = 0; i < 2048; i++) w.push_back(14'(i));
    f = make_frame(w, 1'b0);
    w0 = wa_q.size(); d0 = done_n; e0 = err_n;
    send_frame(f, 0);
    idle(2);
    n_cmp++; if (wa_q.size() - w0 !== 2048) begin n_bad++; $display("FAIL max_nwr got %0d want 2048", wa_q.size() - w0); end
    for (int i = 0; i < 2048 && w0 + i < wa_q.size(); i++) begin
      n_cmp++;
      if (wa_q[w0+i] !== ADDR_W'(i) || wd_q[w0+i] !== 14'(i)) begin
        n_bad++;
        if (bad < 4) $display("FAIL max_wr%0d got a=%h d=%h want a=%h d=%h", i, wa_q[w0+i], wd_q[w0+i], i, i);
        bad++;
      end
    end
    n_cmp++; if (done_n - d0 !== 1 || err_n !== e0) begin n_bad++; $display("FAIL max_done got dones=%0d errs=%0d want 1 0", done_n - d0, err_n - e0); end
    w0 = wa_q.size(); e0 = err_n;
    send_frame('{8'hA5, 8'h08, 8'h01}, 0);
    idle(2);
    n_cmp++; if (err_n - e0 !== 1 || err_code !== 2'd1 || wa_q.size() !== w0) begin n_bad++; $display("FAIL max_over got errs=%0d code=%0d wr=%0d want 1 1 0", err_n - e0, err_code, wa_q.size() - w0); end
  endtask

  task automatic test_noise_reset();
    bq_t noise = '{8'h00, 8'hFF, 8'h5A};
    wq_t w;
    bq_t f;
    int e0 = err_n, d0, w0;
    logic hold0 = cpu_hold;
    logic [1:0] code0 = err_code;
    for (int i = 0; i < 3; i++) begin
      send_byte(noise[i]);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL noise%0d_busy got %b want 0", i, busy); end
    end
    n_cmp++; if (err_n !== e0 || cpu_hold !== hold0 || err_code !== code0) begin n_bad++; $display("FAIL noise_state got errs=%0d hold=%b code=%0d want 0 %b %0d", err_n - e0, cpu_hold, err_code, hold0, code0); end
    w.push_back(14'h0111); w.push_back(14'h0222); w.push_back(14'h0333);
    f = make_frame(w, 1'b0);
    w0 = wa_q.size();
    for (int i = 0; i < 5; i++) send_byte(f[i]);
    idle(1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(2);
    n_cmp++; if (busy !== 1'b0 || cpu_hold !== 1'b1 || err_n !== e0 || err_code !== 2'd0) begin n_bad++; $display("FAIL rst_mid got busy=%b hold=%b errs=%0d code=%0d want 0 1 0 0", busy, cpu_hold, err_n - e0, err_code); end
    n_cmp++; if (wa_q.size() - w0 !== 1) begin n_bad++; $display("FAIL rst_mid_nwr got %0d want 1", wa_q.size() - w0); end
    w0 = wa_q.size(); d0 = done_n;
    send_frame(f, 2);
    idle(2);
    n_cmp++; if (done_n - d0 !== 1 || wa_q.size() - w0 !== 3 || cpu_hold !== 1'b0) begin n_bad++; $display("FAIL rst_reload got dones=%0d wr=%0d hold=%b want 1 3 0", done_n - d0, wa_q.size() - w0, cpu_hold); end
    for (int i = 0; i < 3 && w0 + i < wa_q.size(); i++) begin
      n_cmp++; if (wa_q[w0+i] !== ADDR_W'(i) || wd_q[w0+i] !== w[i]) begin n_bad++; $display("FAIL rst_reload_wr%0d got a=%h d=%h want a=%h d=%h", i, wa_q[w0+i], wd_q[w0+i], i, w[i]); end
    end
    n_cmp++; if (both_n !== 0) begin n_bad++; $display("FAIL done_err_overlap got %0d want 0", both_n); end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_format();
    test_random_frames();
    test_timeout();
    test_max();
    test_noise_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Program-memory writer: the write-side counterpart of the CPU's program fetch path. Receives a framed byte stream from a UART receiver byte interface, assembles 14-bit instruction words, and writes them sequentially into the 2048x14 program RAM from address 0. Holds the CPU in reset while loading and releases it on a checksum-verified frame.

Parameters:
ADDR_W, 11, program memory address width; depth = 2^ADDR_W words
SYNC_BYTE, 8'hA5, frame start byte
TIMEOUT, 1000000, maximum clk cycles allowed between bytes inside a frame
HOLD_AT_RESET, 1, reset value of cpu_hold

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
rx_data  in  8  received byte; valid only when rx_valid=1
rx_valid  in  1  one-cycle strobe per received byte
pm_we  out  1  program memory write enable, one cycle per word
pm_addr  out  ADDR_W  program memory write address
pm_wdata  out  14  instruction word
cpu_hold  out  1  drives CPU rst; high = CPU held in reset
busy  out  1  high while not in IDLE
done  out  1  one-cycle pulse when a frame is accepted
err  out  1  one-cycle pulse when a frame is aborted
err_code  out  2  sticky cause: 0 none, 1 format, 2 timeout, 3 checksum; cleared at next sync

Behaviour:
- Clock and reset: reset rst, synchronous, active-high; clock clk. All outputs are registered.
- Reset values: pm_we=0, pm_addr=0, pm_wdata=0, busy=0, done=0, err=0, err_code=0, cpu_hold=HOLD_AT_RESET. The FSM returns to IDLE. Reset mid-frame aborts with no err pulse.
- Frame format: SYNC, CNT_HI, CNT_LO, then N x (W_HI, W_LO), then CHK.
  - N = {CNT_HI[3:0], CNT_LO}.
  - Word = {W_HI[5:0], W_LO}.
- FSM states: IDLE, CNT_HI, CNT_LO, W_HI, W_LO, CHK. The FSM advances only on cycles with rx_valid=1.
- IDLE:
  - Bytes other than SYNC_BYTE are ignored.
  - On SYNC: go to CNT_HI, clear sum, word index and err_code, and set cpu_hold=1.
- CNT_HI: if rx_data[7:4]!=0, format error; else go to CNT_LO.
- CNT_LO: if N==0 or N>2^ADDR_W, format error; else go to W_HI.
- W_HI: if rx_data[7:6]!=0, format error; else latch the byte and go to W_LO.
- W_LO write:
  - In the cycle after the byte: pm_we=1, pm_addr=index, pm_wdata=word. Write latency is exactly 1 cycle.
  - pm_addr and pm_wdata hold their values after the write.
  - Index increments after each write. Go to CHK after word N, else to W_HI.
  - Words are written as they arrive; a later error does not undo earlier writes.
- Checksum: an 8-bit sum (mod 256) of every byte after SYNC, including CHK.
  - CHK with sum==0: done pulse on the next cycle, cpu_hold=0, return to IDLE.
  - CHK with sum!=0: checksum error.
- Timeout: an in-frame counter is cleared on every rx_valid. If it reaches TIMEOUT with no byte, timeout error. If rx_valid arrives in the expiry cycle, the byte wins.
- Any error:
  - err pulses for 1 cycle and err_code is set.
  - Go to IDLE with cpu_hold remaining 1. Only a later accepted frame releases the CPU.
- A SYNC byte received mid-frame is treated as data, not as a restart.
- busy = (state != IDLE).
- done and err are never high in the same cycle.

Test Plan:
- Good frame: bytes A5 00 02 12 34 00 FF B9 ->
  - pm_we pulses twice: addr0=0x1234, then addr1=0x00FF, each 1 cycle after its W_LO byte.
  - done=1 one cycle after B9; cpu_hold falls 1->0; err_code=0.
- Bad checksum: same frame with final byte B8 ->
  - Both words are still written.
  - err pulse, err_code=3, cpu_hold stays 1, done never asserts.
- Format errors:
  - A5 10 00 (CNT_HI upper nibble set) -> err, err_code=1, no writes.
  - A5 00 00 (N=0) -> err, err_code=1, no writes.
  - A5 00 01 C0 -> err, err_code=1, no writes.
- Timeout with TIMEOUT=16: A5 00 01, then idle ->
  - err pulses exactly 16 cycles after the last byte; err_code=2; busy returns to 0.
  - A byte arriving on cycle 16 is accepted with no error.
- Max/wrap: N=0x800 of incrementing words ->
  - 2048 writes at addr 0..0x7FF, then done.
  - N=0x801 -> err_code=1 at CNT_LO.
- Noise and reset:
  - Bytes 00 FF 5A in IDLE -> no state change, busy=0.
  - rst asserted after the first word of a 3-word frame -> IDLE and cpu_hold=HOLD_AT_RESET, no err; a following good frame loads normally.
